bus_responder: RTL and testbench
================================

# bus_responder

Bus-side slave for the 8085 core's multiplexed external bus: the responding end of the cycles the CPU's decoding/timing sequencer initiates. It demultiplexes AD[7:0] with ALE, decodes memory vs I/O space, serves reads from an internal byte RAM or one I/O register, captures writes, and holds READY low for a fixed number of wait states. Used as the simulation/FPGA memory model attached to the CPU pins.

## Interface
Parameters:
- MEM_AW, 8, internal RAM address width (2^MEM_AW bytes)
- MEM_BASE, 16'h0000, RAM base; bits [15:MEM_AW] compared
- IO_PORT, 8'hF0, port address of the I/O register
- WAIT_STATES, 1, READY-low cycles per hit access (0..7)

Ports:
- clk  in  1  bus clock (CPU CLK out), rising edge active
- reset  in  1  reset, synchronous, active-high
- ale  in  1  address latch enable
- ad_in  in  8  AD bus as seen by the responder
- ad_out  out  8  read data driven onto AD
- ad_oe  out  1  AD output enable
- a_hi  in  8  address A[15:8]
- iom_n  in  1  1 = I/O, 0 = memory
- s1, s0  in  1 each  bus status
- rd_n, wr_n  in  1 each  strobes, active-low
- ready  out  1  wait-state request, active-high
- io_reg  out  8  I/O register contents
- err  out  1  sticky protocol error

## Operation
- FSM states: IDLE, DECODE, WAIT, DATA.
- Any state, ale sampled 1: latch addr = {a_hi, ad_in}, iom_n, s1, s0; ad_oe<=0; state -> DECODE (aborts any access in progress, write not committed).
- DECODE: mem hit = ~iom_n & addr[15:MEM_AW]==MEM_BASE[15:MEM_AW]; io hit = iom_n & addr[7:0]==IO_PORT. Miss -> IDLE, bus untouched, ready stays 1. Hit: WAIT_STATES>0 -> ready<=0, count<=WAIT_STATES, WAIT; else DATA.
- WAIT: count decrements each cycle; edge where count goes 1->0 sets ready<=1, -> DATA.
- DATA read: rd_n sampled 0 -> ad_out<=RAM[addr[MEM_AW-1:0]] or io_reg, ad_oe<=1. rd_n sampled 1 after being 0 -> ad_oe<=0, IDLE.
- DATA write: wr_n sampled 0 -> wdata<=ad_in (last low sample wins). wr_n sampled 1 after being 0 -> commit wdata to RAM/io_reg, IDLE.
- rd_n and wr_n both sampled 0: err<=1, ad_oe<=0, no commit, IDLE.
- RAM contents not reset; addresses wrap modulo 2^MEM_AW inside the hit window.

## Timing
- Reset values: ad_out 0, ad_oe 0, ready 1, io_reg 0, err 0, state IDLE, count 0.
- ale latch at edge n; hit decision registered at n+1; ready low from edge n+1 through edge n+WAIT_STATES, high at n+1+WAIT_STATES.
- Read data: valid with ad_oe one cycle after first rd_n=0 sample; released the cycle after rd_n=1 sample.
- Write: committed on the edge that samples wr_n rising; visible to a following read.
- Strobes asserted during WAIT are held pending; acted on in DATA.
- reset overrides all; err cleared only by reset.

## Configuration
- BUS_RESP_FETCH_CNT_EN defined: adds output fetch_cnt[15:0], reset 0, incremented once per hit read with latched s1=s0=1 (opcode fetch), at the rd_n-rise edge; wraps 16'hFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: after reset, ready=1, ad_oe=0, io_reg=0, err=0.
- Memory write/read, WAIT_STATES=1: write 8'hA5 to 16'h0012, read 16'h0012 -> ad_out=8'hA5, ready low exactly 1 cycle per access.
- I/O: iom_n=1, write 8'h3C to port F0 -> io_reg=8'h3C; read port F1 -> miss, ad_oe stays 0, ready stays 1.
- Abort: ale during DATA with wr_n low, then new read of same address -> old byte returned, no write committed.
- Protocol error: rd_n=wr_n=0 in DATA -> err=1, ad_oe=0, err held until reset.
- BUS_RESP_FETCH_CNT_EN: three reads with s1=s0=1, one with s1=1,s0=0 -> fetch_cnt=3.

Source files
------------

// File: rtl/bus_responder.sv
// bus_responder: slave end of the 8085 multiplexed external bus.
// Demultiplexes AD[7:0] on ALE, decodes memory/I-O space, serves reads from an
// internal byte RAM or a single I/O register, captures writes, and holds READY
// low for WAIT_STATES cycles on every hit access.
//
// Optional feature: define BUS_RESP_FETCH_CNT_EN to add fetch_cnt[15:0], which
// counts completed opcode-fetch reads (latched s1=s0=1) that hit this responder.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no access in progress, bus released
// DECODE | address latched last edge, deciding memory/I-O hit or miss
// WAIT   | hit, READY held low while the wait-state counter runs down
// DATA   | READY high, watching rd_n/wr_n to serve or capture the byte

module bus_responder #(
    parameter int          MEM_AW      = 8,
    parameter logic [15:0] MEM_BASE    = 16'h0000,
    parameter logic [7:0]  IO_PORT     = 8'hF0,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ale,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    input  logic [7:0]  a_hi,
    input  logic        iom_n,
    input  logic        s1,
    input  logic        s0,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic        ready,
    output logic [7:0]  io_reg,
    output logic        err
`ifdef BUS_RESP_FETCH_CNT_EN
    ,
    output logic [15:0] fetch_cnt
`endif
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        WAIT   = 2'd2,
        DATA   = 2'd3
    } state_t;

    state_t      state_q, state_nxt;
    logic [15:0] addr_q, addr_nxt;
    logic        iom_q, iom_nxt;
    logic [1:0]  st_q, st_nxt;
    logic [2:0]  count_q, count_nxt;
    logic        ready_q, ready_nxt;
    logic [7:0]  ad_out_q, ad_out_nxt;
    logic        ad_oe_q, ad_oe_nxt;
    logic [7:0]  io_reg_q, io_reg_nxt;
    logic        err_q, err_nxt;
    logic [7:0]  wdata_q, wdata_nxt;
    logic        rd_seen_q, rd_seen_nxt;
    logic        wr_seen_q, wr_seen_nxt;
    logic        mem_we;
    logic        fetch_inc;
    logic        mem_hit;
    logic        io_hit;
    logic [7:0]  rd_data;

    logic [7:0]  mem [0:(1 << MEM_AW) - 1];

    // Only the bits above the RAM window take part in the base compare, so
    // addresses wrap inside the window.
    assign mem_hit = ~iom_q && (addr_q[15:MEM_AW] == MEM_BASE[15:MEM_AW]);
    assign io_hit  = iom_q && (addr_q[7:0] == IO_PORT);
    assign rd_data = iom_q ? io_reg_q : mem[addr_q[MEM_AW-1:0]];

    // Next-state and next-output logic; ALE restarts the cycle from any state.
    always_comb begin
        state_nxt   = state_q;
        addr_nxt    = addr_q;
        iom_nxt     = iom_q;
        st_nxt      = st_q;
        count_nxt   = count_q;
        ready_nxt   = ready_q;
        ad_out_nxt  = ad_out_q;
        ad_oe_nxt   = ad_oe_q;
        io_reg_nxt  = io_reg_q;
        err_nxt     = err_q;
        wdata_nxt   = wdata_q;
        rd_seen_nxt = rd_seen_q;
        wr_seen_nxt = wr_seen_q;
        mem_we      = 1'b0;
        fetch_inc   = 1'b0;

        if (ale) begin
            // A pending write is dropped here: wr_seen is cleared before commit.
            addr_nxt    = {a_hi, ad_in};
            iom_nxt     = iom_n;
            st_nxt      = {s1, s0};
            ad_oe_nxt   = 1'b0;
            ready_nxt   = 1'b1;
            count_nxt   = 3'd0;
            rd_seen_nxt = 1'b0;
            wr_seen_nxt = 1'b0;
            state_nxt   = DECODE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_nxt = IDLE;
                end
                DECODE: begin
                    if (mem_hit || io_hit) begin
                        if (WS != 3'd0) begin
                            ready_nxt = 1'b0;
                            count_nxt = WS;
                            state_nxt = WAIT;
                        end else begin
                            state_nxt = DATA;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                WAIT: begin
                    count_nxt = count_q - 3'd1;
                    if (count_q == 3'd1) begin
                        ready_nxt = 1'b1;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (!rd_n && !wr_n) begin
                        err_nxt   = 1'b1;
                        ad_oe_nxt = 1'b0;
                        state_nxt = IDLE;
                    end else if (!rd_n) begin
                        ad_out_nxt  = rd_data;
                        ad_oe_nxt   = 1'b1;
                        rd_seen_nxt = 1'b1;
                    end else if (rd_seen_q) begin
                        ad_oe_nxt = 1'b0;
                        fetch_inc = (st_q == 2'b11);
                        state_nxt = IDLE;
                    end else if (!wr_n) begin
                        wdata_nxt   = ad_in;
                        wr_seen_nxt = 1'b1;
                    end else if (wr_seen_q) begin
                        if (iom_q) begin
                            io_reg_nxt = wdata_q;
                        end else begin
                            mem_we = 1'b1;
                        end
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= 16'h0000;
            iom_q     <= 1'b0;
            st_q      <= 2'b00;
            count_q   <= 3'd0;
            ready_q   <= 1'b1;
            ad_out_q  <= 8'h00;
            ad_oe_q   <= 1'b0;
            io_reg_q  <= 8'h00;
            err_q     <= 1'b0;
            wdata_q   <= 8'h00;
            rd_seen_q <= 1'b0;
            wr_seen_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            addr_q    <= addr_nxt;
            iom_q     <= iom_nxt;
            st_q      <= st_nxt;
            count_q   <= count_nxt;
            ready_q   <= ready_nxt;
            ad_out_q  <= ad_out_nxt;
            ad_oe_q   <= ad_oe_nxt;
            io_reg_q  <= io_reg_nxt;
            err_q     <= err_nxt;
            wdata_q   <= wdata_nxt;
            rd_seen_q <= rd_seen_nxt;
            wr_seen_q <= wr_seen_nxt;
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[addr_q[MEM_AW-1:0]] <= wdata_q;
        end
    end

`ifdef BUS_RESP_FETCH_CNT_EN
    // Opcode-fetch counter, bumped on the rd_n-rise edge of a fetch read.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= 16'h0000;
        end else if (fetch_inc) begin
            fetch_cnt <= fetch_cnt + 16'd1;
        end
    end
`else
    // Status bits only feed the fetch counter; tie them off when it is absent.
    logic unused_status;
    assign unused_status = &{1'b0, st_q, fetch_inc};
`endif

    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;
    assign ready  = ready_q;
    assign io_reg = io_reg_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bus_responder.sv
// Testbench for bus_responder: table vectors, hand-written corner sequences
// (abort, protocol error, fetch count) and random transactions against a
// byte-array reference model.

module tb_bus_responder;

    localparam int WS = 1;
    localparam int K  = WS + 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ale = 1'b0;
    logic [7:0]  ad_in = 8'h00;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  a_hi = 8'h00;
    logic        iom_n = 1'b0;
    logic        s1 = 1'b0;
    logic        s0 = 1'b0;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic        ready;
    logic [7:0]  io_reg;
    logic        err;
`ifdef BUS_RESP_FETCH_CNT_EN
    logic [15:0] fetch_cnt;
`endif

    always #5 clk = ~clk;

    bus_responder #(
        .MEM_AW      (8),
        .MEM_BASE    (16'h0000),
        .IO_PORT     (8'hF0),
        .WAIT_STATES (WS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ale       (ale),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .a_hi      (a_hi),
        .iom_n     (iom_n),
        .s1        (s1),
        .s0        (s0),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .ready     (ready),
        .io_reg    (io_reg),
        .err       (err)
`ifdef BUS_RESP_FETCH_CNT_EN
        ,
        .fetch_cnt (fetch_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [7:0] m_mem [256];
    bit         m_valid [256];
    logic [7:0] m_io;
    bit         m_err;
    int         m_fetch;

    typedef struct {
        logic        iom;
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        logic [1:0]  st;
        logic        exp_hit;
        logic [7:0]  exp_rdata;
        logic [7:0]  exp_io;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic iom, input logic [15:0] addr);
        if (iom) return (addr % 256) == 16'h00F0;
        return (addr / 256) == 0;
    endfunction

    function automatic void model_update(input logic iom, input logic [15:0] addr,
                                         input logic [1:0] st, input logic wr,
                                         input logic [7:0] wdata);
        if (!model_hit(iom, addr)) return;
        if (wr) begin
            if (iom) m_io = wdata;
            else begin
                m_mem[addr % 256]   = wdata;
                m_valid[addr % 256] = 1'b1;
            end
        end else if (st == 2'b11) begin
            m_fetch = (m_fetch + 1) % 65536;
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_io    = 8'h00;
        m_err   = 1'b0;
        m_fetch = 0;
    endtask

    task automatic bus_cycle(input logic iom, input logic [15:0] addr, input logic [1:0] st,
                             input logic wr, input logic [7:0] wdata,
                             output int rlow, output logic oe_seen, output logic [7:0] rdata);
        @(negedge clk);
        ale = 1'b1; ad_in = addr[7:0]; a_hi = addr[15:8];
        iom_n = iom; s1 = st[1]; s0 = st[0];
        @(negedge clk);
        ale = 1'b0;
        if (wr) begin
            wr_n = 1'b0; ad_in = wdata;
        end else begin
            rd_n = 1'b0; ad_in = 8'h00;
        end
        rlow = 0; oe_seen = 1'b0; rdata = 8'h00;
        for (int i = 0; i < K; i++) begin
            @(negedge clk);
            if (!ready) rlow++;
            if (ad_oe) begin
                oe_seen = 1'b1;
                rdata   = ad_out;
            end
        end
        rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        chk("oe_release", {31'd0, ad_oe}, 32'd0);
    endtask

    task automatic model_txn(input logic iom, input logic [15:0] addr, input logic [1:0] st,
                             input logic wr, input logic [7:0] wdata);
        int         rlow;
        logic       oe_seen;
        logic [7:0] rdata;
        bit         hit;
        hit = model_hit(iom, addr);
        bus_cycle(iom, addr, st, wr, wdata, rlow, oe_seen, rdata);
        chk("rnd_ready_low", rlow, hit ? WS : 0);
        chk("rnd_oe_seen", {31'd0, oe_seen}, {31'd0, hit && !wr});
        if (hit && !wr && (iom || m_valid[addr % 256]))
            chk("rnd_rdata", {24'd0, rdata}, {24'd0, iom ? m_io : m_mem[addr % 256]});
        model_update(iom, addr, st, wr, wdata);
        chk("rnd_io_reg", {24'd0, io_reg}, {24'd0, m_io});
        chk("rnd_err", {31'd0, err}, {31'd0, m_err});
`ifdef BUS_RESP_FETCH_CNT_EN
        chk("rnd_fetch_cnt", {16'd0, fetch_cnt}, m_fetch);
`endif
    endtask

    initial begin
        int         rlow;
        logic       oe_seen;
        logic [7:0] rdata;
        logic       r_iom, r_wr;
        logic [15:0] r_addr;
        logic [1:0] r_st;

        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;

        //              iom   addr      wr    wdata  st     hit   rdata  io
        vecs[0]  = '{1'b0, 16'h0012, 1'b1, 8'hA5, 2'b10, 1'b1, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 16'h0012, 1'b0, 8'h00, 2'b11, 1'b1, 8'hA5, 8'h00};
        vecs[2]  = '{1'b1, 16'h00F0, 1'b1, 8'h3C, 2'b01, 1'b1, 8'h00, 8'h3C};
        vecs[3]  = '{1'b1, 16'h00F1, 1'b0, 8'h00, 2'b10, 1'b0, 8'h00, 8'h3C};
        vecs[4]  = '{1'b1, 16'h00F0, 1'b0, 8'h00, 2'b10, 1'b1, 8'h3C, 8'h3C};
        vecs[5]  = '{1'b0, 16'h00FF, 1'b1, 8'h5A, 2'b01, 1'b1, 8'h00, 8'h3C};
        vecs[6]  = '{1'b0, 16'h00FF, 1'b0, 8'h00, 2'b10, 1'b1, 8'h5A, 8'h3C};
        vecs[7]  = '{1'b0, 16'h0112, 1'b1, 8'h66, 2'b01, 1'b0, 8'h00, 8'h3C};
        vecs[8]  = '{1'b0, 16'h0100, 1'b0, 8'h00, 2'b10, 1'b0, 8'h00, 8'h3C};
        vecs[9]  = '{1'b1, 16'h12F0, 1'b1, 8'hC3, 2'b01, 1'b1, 8'h00, 8'hC3};
        vecs[10] = '{1'b0, 16'h00F0, 1'b1, 8'h99, 2'b01, 1'b1, 8'h00, 8'hC3};
        vecs[11] = '{1'b1, 16'h00F0, 1'b0, 8'h00, 2'b10, 1'b1, 8'hC3, 8'hC3};
        vecs[12] = '{1'b0, 16'h00F0, 1'b0, 8'h00, 2'b11, 1'b1, 8'h99, 8'hC3};
        vecs[13] = '{1'b0, 16'h0012, 1'b0, 8'h00, 2'b10, 1'b1, 8'hA5, 8'hC3};

        // reset state
        do_reset();
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_ad_oe", {31'd0, ad_oe}, 32'd0);
        chk("rst_ad_out", {24'd0, ad_out}, 32'd0);
        chk("rst_io_reg", {24'd0, io_reg}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
`ifdef BUS_RESP_FETCH_CNT_EN
        chk("rst_fetch_cnt", {16'd0, fetch_cnt}, 32'd0);
`endif

        // table vectors
        foreach (vecs[i]) begin
            bus_cycle(vecs[i].iom, vecs[i].addr, vecs[i].st, vecs[i].wr, vecs[i].wdata,
                      rlow, oe_seen, rdata);
            chk($sformatf("vec%0d_ready_low", i), rlow, vecs[i].exp_hit ? WS : 0);
            chk($sformatf("vec%0d_oe_seen", i), {31'd0, oe_seen},
                {31'd0, vecs[i].exp_hit && !vecs[i].wr});
            if (vecs[i].exp_hit && !vecs[i].wr)
                chk($sformatf("vec%0d_rdata", i), {24'd0, rdata}, {24'd0, vecs[i].exp_rdata});
            chk($sformatf("vec%0d_io_reg", i), {24'd0, io_reg}, {24'd0, vecs[i].exp_io});
            model_update(vecs[i].iom, vecs[i].addr, vecs[i].st, vecs[i].wr, vecs[i].wdata);
        end
`ifdef BUS_RESP_FETCH_CNT_EN
        chk("vec_fetch_cnt", {16'd0, fetch_cnt}, 32'd2);
`endif

        // abort: ALE during DATA with wr_n low must drop the write
        @(negedge clk);
        ale = 1'b1; ad_in = 8'h12; a_hi = 8'h00; iom_n = 1'b0; s1 = 1'b0; s0 = 1'b1;
        @(negedge clk);
        ale = 1'b0; wr_n = 1'b0; ad_in = 8'h77;
        repeat (K) @(negedge clk);
        ale = 1'b1; ad_in = 8'h34; a_hi = 8'h12;
        @(negedge clk);
        ale = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_ad_oe", {31'd0, ad_oe}, 32'd0);
        bus_cycle(1'b0, 16'h0012, 2'b10, 1'b0, 8'h00, rlow, oe_seen, rdata);
        chk("abort_oe_seen", {31'd0, oe_seen}, 32'd1);
        chk("abort_old_byte", {24'd0, rdata}, 32'h0000_00A5);

        // protocol error: both strobes low in DATA
        @(negedge clk);
        ale = 1'b1; ad_in = 8'h12; a_hi = 8'h00; iom_n = 1'b0; s1 = 1'b1; s0 = 1'b0;
        @(negedge clk);
        ale = 1'b0; rd_n = 1'b0; wr_n = 1'b0; ad_in = 8'hEE;
        oe_seen = 1'b0;
        for (int i = 0; i < K; i++) begin
            @(negedge clk);
            if (ad_oe) oe_seen = 1'b1;
        end
        chk("perr_err", {31'd0, err}, 32'd1);
        chk("perr_oe_seen", {31'd0, oe_seen}, 32'd0);
        rd_n = 1'b1; wr_n = 1'b1;
        m_err = 1'b1;
        bus_cycle(1'b0, 16'h0012, 2'b10, 1'b0, 8'h00, rlow, oe_seen, rdata);
        chk("perr_no_commit", {24'd0, rdata}, 32'h0000_00A5);
        chk("perr_err_sticky", {31'd0, err}, 32'd1);
        do_reset();
        chk("perr_err_cleared", {31'd0, err}, 32'd0);

        // fetch counting: three opcode fetches and one plain read
        model_txn(1'b0, 16'h0012, 2'b11, 1'b0, 8'h00);
        model_txn(1'b0, 16'h0012, 2'b11, 1'b0, 8'h00);
        model_txn(1'b0, 16'h0012, 2'b10, 1'b0, 8'h00);
        model_txn(1'b0, 16'h0012, 2'b11, 1'b0, 8'h00);
`ifdef BUS_RESP_FETCH_CNT_EN
        chk("fetch_cnt_three", {16'd0, fetch_cnt}, 32'd3);
`endif

        // random transactions against the model
        for (int t = 0; t < 80; t++) begin
            r_iom = ($urandom_range(0, 3) == 0);
            r_wr  = $urandom_range(0, 1) == 1;
            r_st  = 2'($urandom_range(0, 3));
            if (r_iom)
                r_addr = {8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hF0};
            else
                r_addr = ($urandom_range(0, 4) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
            model_txn(r_iom, r_addr, r_st, r_wr, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
